mult_scoreboard: RTL and testbench
==================================

# mult_scoreboard

Issue scheduler for the decode stage that arbitrates the shared register-file write port and register operands between the single-cycle ALU/memory pipeline and the multi-cycle multiply pipeline. It tracks every in-flight multiply in a shift-register scoreboard and generates the decode stall, which gates PC and IF/ID writes and inserts a bubble into ID/EX. It also drives the multiply-pipeline writeback request to the register file.

## Interface
Parameters:
- MUL_LAT, 6, cycles from multiply issue to its writeback cycle; must exceed ALU_LAT.
- ALU_LAT, 3, cycles from non-multiply issue to its writeback cycle.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- d_valid  in  1  decode holds a valid instruction.
- d_is_mult  in  1  decode instruction is a multiply.
- d_regwrite  in  1  decode instruction writes a register.
- d_dest_reg  in  RA_W  decode destination register.
- d_src1  in  RA_W  decode source register 1.
- d_src2  in  RA_W  decode source register 2.
- d_use_src2  in  1  src2 is a real operand; immediate forms drive 0.
- flush  in  1  kill the decode instruction (taken branch or jump).
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- issue  out  1  decode instruction leaves decode this cycle.
- wb_mul_valid  out  1  multiply result writes the register file this cycle.
- wb_mul_dest  out  RA_W  multiply writeback destination.
- mul_busy  out  1  at least one multiply is in flight.

## Operation
- State: MUL_LAT slots, slot[0] to slot[MUL_LAT-1], each holding {v, dest}.
- Every cycle, the slots shift down: slot[k] takes slot[k+1]; slot[MUL_LAT-1] is loaded with {issue & d_is_mult & d_regwrite, d_dest_reg}. The shift is never frozen by stall, because downstream stages keep advancing.
- wb_mul_valid equals slot[0].v; wb_mul_dest equals slot[0].dest. Both are combinational from state.
- Register r0 is never tracked: a dest of 0 loads v=0, and a source of 0 never matches.
- Hazard terms are evaluated over all slots k = 0..MUL_LAT-1:
  - raw: slot[k].v and (slot[k].dest == d_src1, or d_use_src2 and slot[k].dest == d_src2). Slot[0] counts, because the register file write lands on the edge after the read.
  - waw: d_regwrite, not d_is_mult, and some slot[k].v with slot[k].dest == d_dest_reg.
  - port: d_regwrite, not d_is_mult, and slot[ALU_LAT].v. This is a writeback-port collision.
- stall = d_valid & ~flush & (raw | waw | port).
- issue = d_valid & ~flush & ~stall.
- mul_busy = OR of all slot[k].v.
- Multiply after multiply never conflicts: at most one issue per cycle and a fixed latency give distinct writeback cycles.

## Timing
- Reset values: every slot v=0 and dest=0. Consequently stall=0, issue=d_valid & ~flush, wb_mul_valid=0, wb_mul_dest=0, mul_busy=0.
- stall and issue are combinational in the same cycle as the decode inputs; there is no added latency.
- A multiply issued in cycle t has its writeback in cycle t+MUL_LAT.
- A non-multiply issued in cycle t has its writeback in cycle t+ALU_LAT.
- A dependent instruction stalled on a multiply issues in cycle t+MUL_LAT+1.
- flush and a hazard in the same cycle: flush wins, so stall=0 and issue=0.
- Reset asserted mid-operation discards all in-flight entries. On release, the first posedge resumes shifting from empty.

## Configuration
- MULT_SCOREBOARD_STATS_EN:
  - Defined: adds outputs stall_cycles[31:0] and mul_issued[31:0].
    - stall_cycles increments every cycle stall=1.
    - mul_issued increments on issue & d_is_mult.
    - Both wrap modulo 2^32 and clear on reset.
  - Undefined: the counters and their ports are absent, and the remaining behaviour is identical.

## Test plan
- Reset, then single multiply: mul r3 issued at cycle 10 -> slot[5] valid at 11; wb_mul_valid=1 with dest=3 in cycle 16 only; mul_busy high cycles 11-16.
- RAW: mul r3 at cycle 10, then add r4,r3,r1 presented at cycle 11 -> stall=1 in cycles 11-16; issue=1 in cycle 17.
- Port collision: mul r5 at cycle 10, then add r6,r1,r2 presented at cycle 13 (slot[3] valid) -> stall in 13, issue in 14; mul WB at 16, add WB at 17.
- WAW: mul r7 at cycle 10, then addi r7 at cycle 11 -> stall until slot with dest 7 clears; issue in 17. A load to r0 at cycle 11 issues immediately.
- Flush: hazard present and flush=1 in the same cycle -> stall=0, issue=0; in-flight slots keep shifting.
- Async reset with three multiplies in flight -> mul_busy and wb_mul_valid drop before the next edge; with STATS_EN both counters read 0.

Source files
------------

// File: rtl/mult_scoreboard.sv
// Decode-stage issue scheduler for the shared register-file write port.
// Tracks in-flight multiplies in a shift-register scoreboard and raises a
// decode stall on RAW/WAW hazards and on writeback-port collisions.
// Optional feature macro: MULT_SCOREBOARD_STATS_EN (stall/issue counters).
module mult_scoreboard #(
  parameter int unsigned MUL_LAT = 6,
  parameter int unsigned ALU_LAT = 3,
  parameter int unsigned RA_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_valid,
  input  logic            d_is_mult,
  input  logic            d_regwrite,
  input  logic [RA_W-1:0] d_dest_reg,
  input  logic [RA_W-1:0] d_src1,
  input  logic [RA_W-1:0] d_src2,
  input  logic            d_use_src2,
  input  logic            flush,
  output logic            stall,
  output logic            issue,
  output logic            wb_mul_valid,
  output logic [RA_W-1:0] wb_mul_dest,
`ifdef MULT_SCOREBOARD_STATS_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     mul_issued,
`endif
  output logic            mul_busy
);

  // slot[0] is the multiply writing back this cycle; slot[MUL_LAT-1] was issued last cycle
  logic [MUL_LAT-1:0] slot_v_q;
  logic [RA_W-1:0]    slot_dest_q [MUL_LAT];

  logic raw, waw, port;
  logic mul_load_v;

  // r0 is never tracked, so a multiply to r0 enters the scoreboard as empty
  assign mul_load_v = issue & d_is_mult & d_regwrite & (d_dest_reg != '0);

  // Scoreboard shift; keeps advancing while decode is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_v_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        slot_dest_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MUL_LAT - 1; k++) begin
        slot_v_q[k]    <= slot_v_q[k+1];
        slot_dest_q[k] <= slot_dest_q[k+1];
      end
      slot_v_q[MUL_LAT-1]    <= mul_load_v;
      slot_dest_q[MUL_LAT-1] <= d_dest_reg;
    end
  end

  // Hazard detection against every in-flight multiply, including the one writing back now
  always_comb begin
    raw  = 1'b0;
    waw  = 1'b0;
    port = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) begin
      if (slot_v_q[k]) begin
        if ((d_src1 != '0) && (slot_dest_q[k] == d_src1)) begin
          raw = 1'b1;
        end
        if (d_use_src2 && (d_src2 != '0) && (slot_dest_q[k] == d_src2)) begin
          raw = 1'b1;
        end
        if (d_regwrite && !d_is_mult && (slot_dest_q[k] == d_dest_reg)) begin
          waw = 1'b1;
        end
      end
    end
    // A non-multiply issued now would write back in the same cycle as slot[ALU_LAT]
    if (d_regwrite && !d_is_mult && slot_v_q[ALU_LAT]) begin
      port = 1'b1;
    end
  end

  // Decode handshake; flush overrides any hazard
  always_comb begin
    stall = d_valid & ~flush & (raw | waw | port);
    issue = d_valid & ~flush & ~stall;
  end

  assign wb_mul_valid = slot_v_q[0];
  assign wb_mul_dest  = slot_dest_q[0];
  assign mul_busy     = |slot_v_q;

`ifdef MULT_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] mul_issued_q;

  // Free-running statistics, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      mul_issued_q   <= '0;
    end else begin
      if (stall) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (issue && d_is_mult) begin
        mul_issued_q <= mul_issued_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign mul_issued   = mul_issued_q;
`endif

endmodule

// File: tb/tb_mult_scoreboard.sv
// Randomized bench for mult_scoreboard against a history-based reference model.
// Honors MULT_SCOREBOARD_STATS_EN when the RTL is built with it.
module tb_mult_scoreboard;

  localparam int unsigned L  = 6;
  localparam int unsigned A  = 3;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_valid, d_is_mult, d_regwrite, d_use_src2, flush;
  logic [RW-1:0] d_dest_reg, d_src1, d_src2;
  logic          stall, issue, wb_mul_valid, mul_busy;
  logic [RW-1:0] wb_mul_dest;
`ifdef MULT_SCOREBOARD_STATS_EN
  logic [31:0]   stall_cycles, mul_issued;
  logic [31:0]   sc_exp, mc_exp;
`endif

  always #5 clk = ~clk;

  mult_scoreboard #(.MUL_LAT(L), .ALU_LAT(A), .RA_W(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_valid      (d_valid),
    .d_is_mult    (d_is_mult),
    .d_regwrite   (d_regwrite),
    .d_dest_reg   (d_dest_reg),
    .d_src1       (d_src1),
    .d_src2       (d_src2),
    .d_use_src2   (d_use_src2),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .wb_mul_valid (wb_mul_valid),
    .wb_mul_dest  (wb_mul_dest),
`ifdef MULT_SCOREBOARD_STATS_EN
    .stall_cycles (stall_cycles),
    .mul_issued   (mul_issued),
`endif
    .mul_busy     (mul_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // History of what each posedge captured: hv = a tracked multiply issued, hd = dest seen.
  // Entries older than base were wiped by a reset.
  bit            hv [8192];
  logic [RW-1:0] hd [8192];
  int            n    = 0;
  int            base = 1;
  bit            exp_stall, exp_issue;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit ent_v(int idx);
    return (idx >= base && idx >= 1) ? hv[idx] : 1'b0;
  endfunction

  function automatic logic [RW-1:0] ent_d(int idx);
    return (idx >= base && idx >= 1) ? hd[idx] : '0;
  endfunction

  // A multiply issued at posedge-index i writes back in cycle i+L-1; it is in flight
  // from cycle i through i+L-1 and a non-multiply issued now lands on its writeback
  // when i = n-(L-1-A).
  task automatic eval_and_check();
    bit raw = 0, waw = 0, port = 0, busy = 0;
    for (int j = 0; j < L; j++) begin
      int idx = n - j;
      if (ent_v(idx)) begin
        busy = 1;
        if (d_src1 != 0 && hd[idx] == d_src1) raw = 1;
        if (d_use_src2 && d_src2 != 0 && hd[idx] == d_src2) raw = 1;
        if (d_regwrite && !d_is_mult && hd[idx] == d_dest_reg) waw = 1;
      end
    end
    if (d_regwrite && !d_is_mult && ent_v(n - (L - 1 - A))) port = 1;
    exp_stall = d_valid && !flush && (raw || waw || port);
    exp_issue = d_valid && !flush && !exp_stall;
    check("stall", stall, exp_stall);
    check("issue", issue, exp_issue);
    check("wb_mul_valid", wb_mul_valid, ent_v(n - (L - 1)));
    check("wb_mul_dest", wb_mul_dest, ent_d(n - (L - 1)));
    check("mul_busy", mul_busy, busy);
`ifdef MULT_SCOREBOARD_STATS_EN
    check("stall_cycles", stall_cycles, sc_exp);
    check("mul_issued", mul_issued, mc_exp);
`endif
  endtask

  task automatic record();
    n++;
    if (reset) begin
      base = n + 1;
`ifdef MULT_SCOREBOARD_STATS_EN
      sc_exp = '0;
      mc_exp = '0;
`endif
    end else begin
      hv[n] = exp_issue && d_is_mult && d_regwrite && (d_dest_reg != 0);
      hd[n] = d_dest_reg;
`ifdef MULT_SCOREBOARD_STATS_EN
      if (exp_stall) sc_exp = sc_exp + 32'd1;
      if (exp_issue && d_is_mult) mc_exp = mc_exp + 32'd1;
`endif
    end
  endtask

  // Check mid-cycle, capture at the edge, return just after the edge
  task automatic run_cycle();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    record();
    #1;
  endtask

  task automatic rand_inputs();
    d_valid    = ($urandom_range(0, 9) != 0);
    d_is_mult  = ($urandom_range(0, 2) == 0);
    d_regwrite = ($urandom_range(0, 4) != 0);
    d_dest_reg = RW'($urandom_range(0, 7));
    d_src1     = RW'($urandom_range(0, 7));
    d_src2     = RW'($urandom_range(0, 7));
    d_use_src2 = $urandom_range(0, 1) == 1;
    flush      = ($urandom_range(0, 9) == 0);
  endtask

  task automatic drive_mul(input logic [RW-1:0] dst);
    d_valid = 1; d_is_mult = 1; d_regwrite = 1; d_dest_reg = dst;
    d_src1 = 0; d_src2 = 0; d_use_src2 = 0; flush = 0;
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      // A stalled instruction stays in decode, as the real pipeline would hold it
      if (!exp_stall) rand_inputs();
      else flush = ($urandom_range(0, 9) == 0);
      run_cycle();
    end
  endtask

  initial begin
`ifdef MULT_SCOREBOARD_STATS_EN
    sc_exp = '0;
    mc_exp = '0;
`endif
    exp_stall = 0;
    exp_issue = 0;
    reset = 1;
    rand_inputs();
    run_cycle();
    run_cycle();
    reset = 0;

    random_phase(1500);

    // Three multiplies in flight, then an asynchronous reset between edges
    drive_mul(5'd3); run_cycle();
    drive_mul(5'd4); run_cycle();
    drive_mul(5'd5); run_cycle();
    d_valid = 0;
    #2;
    reset = 1;
    #1;
    check("async_rst_busy", mul_busy, 1'b0);
    check("async_rst_wb", wb_mul_valid, 1'b0);
`ifdef MULT_SCOREBOARD_STATS_EN
    check("async_rst_stalls", stall_cycles, 32'd0);
    check("async_rst_muls", mul_issued, 32'd0);
`endif
    base = n + 1;
`ifdef MULT_SCOREBOARD_STATS_EN
    sc_exp = '0;
    mc_exp = '0;
`endif
    run_cycle();
    reset = 0;
    exp_stall = 0;

    random_phase(800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
